conv3x3_engine: RTL and testbench
=================================

Name: conv3x3_engine

Overview:
Parametrised, pipelined 3x3 convolution engine with a runtime-programmable signed kernel, a programmable normalising shift with rounding, border-tap masking and output saturation. It sits between the line-buffer/window generator and the pixel output stage. Data moves on a valid/ready stream with full back-pressure. Presets cover the diagonal-Laplacian and Gaussian kernels the filter chain already uses.

Parameters:
DATA_WIDTH, 8, unsigned pixel width (in and out)
COEF_WIDTH, 5, signed two's-complement coefficient width (2..8)
ACC_WIDTH, DATA_WIDTH+COEF_WIDTH+5, internal signed accumulator width (localparam, derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  config write strobe
cfg_addr  in  4  0..8 coefficient tap k (row-major, tap 4 = centre), 9 shift, 10 preset load
cfg_wdata  in  8  write data; coefficients use [COEF_WIDTH-1:0], shift uses [3:0]
in_valid  in  1  window valid
in_ready  out  1  engine accepts window
in_pix  in  9*DATA_WIDTH  window, tap k at [k*DATA_WIDTH +: DATA_WIDTH]
in_border  in  4  border code, selects tap-enable mask
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_pix  out  DATA_WIDTH  saturated result
out_clip  out  1  result was saturated

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_pix=0, out_clip=0, all stage valids 0. Kernel = diagonal Laplacian [-1 0 -1; 0 4 0; -1 0 -1], shift=0.
- in_ready = ~v3 | out_ready, where v3 is the stage-3 valid. The single advance signal adv = in_ready enables all stages; while adv=0 every stage register holds.
- Stage 1 (on in_valid & adv): decode the mask from in_border. Compute product k = mask[k] ? zext(pix_k) * coef_k : 0, signed, ACC_WIDTH wide. Register all nine products.
- Stage 2: register the three row sums.
- Stage 3: compute total. If shift>0, add 2^(shift-1), then arithmetic right shift by shift. Saturate: <0 gives 0 with clip=1; >2^DATA_WIDTH-1 gives max with clip=1; otherwise the value with clip=0. Register into out_pix/out_clip.
- Latency is 3 cycles from accept to out_valid when unstalled. Throughput is 1 window per cycle. Order is preserved, with no drops and no duplicates.
- Stage valids: v1<=in_valid, v2<=v1, v3<=v2, each updated only when adv=1. Bubbles propagate as invalid.
- Border mask table: 0: none (result 0); 1: {0,4}; 2: {2,4}; 3: {0,4,6}; 4: {2,4,8}; 5: {4,6}; 6: {4,8}; 7..15: all nine taps.
- Config writes take effect the next cycle and are independent of adv.
- A window captured into stage 1 uses the coefficients and shift in effect before any same-cycle cfg write. Shift is sampled at stage 1 and carried down the pipe, so in-flight windows are never retroactively altered.
- Preset (addr 10), applied atomically in one cycle:
  - wdata[0]=0: Laplacian, shift 0.
  - wdata[0]=1: Gaussian [1 2 1; 2 4 2; 1 2 1], shift 4.
- cfg_addr 11..15: write ignored.
- Coefficient values outside the COEF_WIDTH range are truncated to COEF_WIDTH bits, with no error.
- Asserting reset mid-stream clears all valids immediately and discards in-flight windows. The kernel returns to the Laplacian default.

Decomposition:
- Package conv3x3_pkg: border-code constants and the mask table function; preset IDs; Laplacian and Gaussian coefficient constants; cfg address constants.
- One sub-module, conv3x3_round_sat: combinational round, shift and saturate, parametrised on ACC_WIDTH/DATA_WIDTH.
- Products and adder tree stay inline.

Test Plan:
- Reset defaults: all pixels 100, border 8, in_valid one beat. Expect out_pix 0, clip 0, 3 cycles after accept.
- Saturation: centre 100, others 0, border 8, Laplacian. Expect 400 saturated to out_pix 255, clip 1.
- Negative clip: centre 0, corners 10. Expect out_pix 0, clip 1.
- Gaussian preset with rounding:
  - All pixels 100: expect 1600>>4 = 100.
  - Centre 3, others 0: expect (12+8)>>4 = 1, clip 0.
- Border mask: code 1, Laplacian, p0=50, centre=20, others 255. Expect 80-50 = 30. Code 0 with any data: expect 0.
- Back-pressure and ordering:
  - Stream 6 distinct windows with out_ready low for 5 cycles mid-burst. Expect in_ready low while the pipe is full and outputs in order with no loss or duplication.
  - A cfg write during the stall does not alter already-captured windows.
  - Assert rst_n low mid-burst: out_valid drops the same cycle and the kernel reads back as Laplacian behaviour afterwards.

Source files
------------

// File: rtl/conv3x3_pkg.sv
// Shared definitions for the 3x3 convolution engine.
// Holds the border codes and their tap-enable table, preset identifiers,
// the Laplacian and Gaussian kernel constants and the config address map.
package conv3x3_pkg;

    // Border codes: the name lists the corner taps kept besides the centre.
    localparam logic [3:0] BORDER_NONE   = 4'd0;
    localparam logic [3:0] BORDER_TAP0   = 4'd1;
    localparam logic [3:0] BORDER_TAP2   = 4'd2;
    localparam logic [3:0] BORDER_TAP06  = 4'd3;
    localparam logic [3:0] BORDER_TAP28  = 4'd4;
    localparam logic [3:0] BORDER_TAP6   = 4'd5;
    localparam logic [3:0] BORDER_TAP8   = 4'd6;

    localparam logic [8:0] MASK_ALL      = 9'h1FF;

    // Preset identifiers carried in cfg_wdata[0].
    localparam logic PRESET_LAPLACIAN    = 1'b0;
    localparam logic PRESET_GAUSSIAN     = 1'b1;

    // Kernels packed 8 bits per tap, tap k at [k*8 +: 8] (tap 8 is the MSB byte).
    localparam logic [71:0] LAP_COEFS = {8'hFF, 8'h00, 8'hFF,
                                         8'h00, 8'h04, 8'h00,
                                         8'hFF, 8'h00, 8'hFF};
    localparam logic [71:0] GAUSS_COEFS = {8'h01, 8'h02, 8'h01,
                                           8'h02, 8'h04, 8'h02,
                                           8'h01, 8'h02, 8'h01};
    localparam logic [3:0]  LAP_SHIFT   = 4'd0;
    localparam logic [3:0]  GAUSS_SHIFT = 4'd4;

    // Configuration address map.
    localparam logic [3:0] CFG_TAP_LAST = 4'd8;
    localparam logic [3:0] CFG_SHIFT    = 4'd9;
    localparam logic [3:0] CFG_PRESET   = 4'd10;

    // Tap-enable mask for a border code; bit k enables tap k.
    function automatic logic [8:0] border_mask(input logic [3:0] code);
        logic [8:0] mask;
        case (code)
            BORDER_NONE:  mask = 9'h000;
            BORDER_TAP0:  mask = 9'h011;
            BORDER_TAP2:  mask = 9'h014;
            BORDER_TAP06: mask = 9'h051;
            BORDER_TAP28: mask = 9'h114;
            BORDER_TAP6:  mask = 9'h050;
            BORDER_TAP8:  mask = 9'h110;
            default:      mask = MASK_ALL;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/conv3x3_round_sat.sv
// Combinational round / normalise / saturate for the convolution total.
// Ports:
//   acc   - signed accumulator total
//   shift - normalising right shift (0 = no rounding, no shift)
//   pix   - unsigned result clamped to [0, 2^DATA_WIDTH-1]
//   clip  - high when the result had to be clamped
module conv3x3_round_sat #(
    parameter int ACC_WIDTH  = 18,
    parameter int DATA_WIDTH = 8
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    input  logic [3:0]                  shift,
    output logic [DATA_WIDTH-1:0]       pix,
    output logic                        clip
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam logic signed [ACC_WIDTH:0] ONE = {{ACC_WIDTH{1'b0}}, 1'b1};

    logic signed [ACC_WIDTH:0] rnd_s;
    logic signed [ACC_WIDTH:0] sum_s;
    logic signed [ACC_WIDTH:0] shifted_s;

    // Round half up, arithmetic shift, then clamp into the pixel range.
    always_comb begin
        rnd_s     = '0;
        pix       = '0;
        clip      = 1'b0;
        if (shift != 4'd0) begin
            rnd_s = ONE <<< (shift - 4'd1);
        end else begin
            rnd_s = '0;
        end
        sum_s     = {acc[ACC_WIDTH-1], acc} + rnd_s;
        shifted_s = sum_s >>> shift;
        if (shifted_s[ACC_WIDTH]) begin
            pix  = '0;
            clip = 1'b1;
        end else if (|shifted_s[ACC_WIDTH-1:DATA_WIDTH]) begin
            pix  = '1;
            clip = 1'b1;
        end else begin
            pix  = shifted_s[DATA_WIDTH-1:0];
            clip = 1'b0;
        end
    end

endmodule

// File: rtl/conv3x3_engine.sv
// Pipelined 3x3 convolution engine with programmable signed kernel,
// rounding normalise shift, border-tap masking and output saturation.
// Ports:
//   clk, rst_n              - clock, async active-low reset
//   cfg_we/cfg_addr/cfg_wdata - config: taps 0..8, 9 shift, 10 preset
//   in_valid/in_ready/in_pix/in_border - window stream in (tap k at k*DATA_WIDTH)
//   out_valid/out_ready/out_pix/out_clip - result stream out
// Three register stages (products, row sums, round/saturate), one common
// advance enable so the whole pipe stalls as a unit under back-pressure.
module conv3x3_engine
    import conv3x3_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [3:0]              cfg_addr,
    input  logic [7:0]              cfg_wdata,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [9*DATA_WIDTH-1:0] in_pix,
    input  logic [3:0]              in_border,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_pix,
    output logic                    out_clip
);

    localparam int ACC_WIDTH = DATA_WIDTH + COEF_WIDTH + 5;

    logic [COEF_WIDTH-1:0]        coef_r [9];
    logic [3:0]                   shift_r;

    logic                         adv_s;
    logic                         v1_r, v2_r, v3_r;
    logic [8:0]                   mask_s;
    logic signed [ACC_WIDTH-1:0]  pix_ext_s, coef_ext_s;
    logic signed [ACC_WIDTH-1:0]  prod_s  [9];
    logic signed [ACC_WIDTH-1:0]  prod1_r [9];
    logic [3:0]                   shift1_r, shift2_r;
    logic signed [ACC_WIDTH-1:0]  row2_r  [3];
    logic signed [ACC_WIDTH-1:0]  total_s;
    logic [DATA_WIDTH-1:0]        rs_pix_s;
    logic                         rs_clip_s;
    logic [DATA_WIDTH-1:0]        out_pix_r;
    logic                         out_clip_r;
    logic                         unused_cfg_s;

    // Not every write-data bit is meaningful for every address/width.
    assign unused_cfg_s = ^cfg_wdata;

    // Stage 3 frees up whenever it is empty or being drained.
    assign in_ready  = ~v3_r | out_ready;
    assign adv_s     = in_ready;
    assign out_valid = v3_r;
    assign out_pix   = out_pix_r;
    assign out_clip  = out_clip_r;

    // Kernel and shift registers; writes are independent of the pipe stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++) begin
                coef_r[k] <= LAP_COEFS[k*8 +: COEF_WIDTH];
            end
            shift_r <= LAP_SHIFT;
        end else if (cfg_we) begin
            case (cfg_addr)
                CFG_SHIFT: shift_r <= cfg_wdata[3:0];
                CFG_PRESET: begin
                    for (int k = 0; k < 9; k++) begin
                        coef_r[k] <= (cfg_wdata[0] == PRESET_GAUSSIAN) ?
                                     GAUSS_COEFS[k*8 +: COEF_WIDTH] :
                                     LAP_COEFS[k*8 +: COEF_WIDTH];
                    end
                    shift_r <= (cfg_wdata[0] == PRESET_GAUSSIAN) ? GAUSS_SHIFT : LAP_SHIFT;
                end
                default: begin
                    // Addresses above the tap range are silently ignored.
                    if (cfg_addr <= CFG_TAP_LAST) begin
                        coef_r[cfg_addr] <= cfg_wdata[COEF_WIDTH-1:0];
                    end
                end
            endcase
        end
    end

    // Masked products: pixel zero-extended, coefficient sign-extended.
    always_comb begin
        mask_s     = border_mask(in_border);
        pix_ext_s  = '0;
        coef_ext_s = '0;
        for (int k = 0; k < 9; k++) begin
            pix_ext_s  = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, in_pix[k*DATA_WIDTH +: DATA_WIDTH]};
            coef_ext_s = {{(ACC_WIDTH-COEF_WIDTH){coef_r[k][COEF_WIDTH-1]}}, coef_r[k]};
            if (mask_s[k]) begin
                prod_s[k] = pix_ext_s * coef_ext_s;
            end else begin
                prod_s[k] = '0;
            end
        end
    end

    // Stage valids move together on advance; bubbles travel as invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
            v3_r <= 1'b0;
        end else if (adv_s) begin
            v1_r <= in_valid;
            v2_r <= v1_r;
            v3_r <= v2_r;
        end
    end

    // Stage 1: capture products and the shift in force at capture time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++) begin
                prod1_r[k] <= '0;
            end
            shift1_r <= 4'd0;
        end else if (adv_s && in_valid) begin
            for (int k = 0; k < 9; k++) begin
                prod1_r[k] <= prod_s[k];
            end
            shift1_r <= shift_r;
        end
    end

    // Stage 2: row sums, shift carried alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                row2_r[r] <= '0;
            end
            shift2_r <= 4'd0;
        end else if (adv_s && v1_r) begin
            for (int r = 0; r < 3; r++) begin
                row2_r[r] <= prod1_r[3*r] + prod1_r[3*r+1] + prod1_r[3*r+2];
            end
            shift2_r <= shift1_r;
        end
    end

    assign total_s = row2_r[0] + row2_r[1] + row2_r[2];

    conv3x3_round_sat #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_round_sat (
        .acc   (total_s),
        .shift (shift2_r),
        .pix   (rs_pix_s),
        .clip  (rs_clip_s)
    );

    // Stage 3: register the saturated result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pix_r  <= '0;
            out_clip_r <= 1'b0;
        end else if (adv_s && v2_r) begin
            out_pix_r  <= rs_pix_s;
            out_clip_r <= rs_clip_s;
        end
    end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Self-checking bench for conv3x3_engine. A monitor process predicts each
// accepted window with an integer model and compares results in order.
module tb_conv3x3_engine;

    localparam int DW = 8;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_we;
    logic [3:0]    cfg_addr;
    logic [7:0]    cfg_wdata;
    logic          in_valid;
    logic          in_ready;
    logic [71:0]   in_pix;
    logic [3:0]    in_border;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_pix;
    logic          out_clip;

    int            n_checks = 0;
    int            n_errors = 0;
    int            n_out    = 0;
    logic [8:0]    exp_q [$];
    int            m_coef [9];
    int            m_shift;

    always #5 clk = ~clk;

    conv3x3_engine #(.DATA_WIDTH(DW), .COEF_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix), .in_border(in_border),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix), .out_clip(out_clip)
    );

    function automatic void model_reset();
        m_coef  = '{-1, 0, -1, 0, 4, 0, -1, 0, -1};
        m_shift = 0;
    endfunction

    function automatic int sext(input logic [7:0] d);
        logic signed [CW-1:0] t;
        t = d[CW-1:0];
        return int'(t);
    endfunction

    function automatic void model_cfg(input logic [3:0] a, input logic [7:0] d);
        if (a <= 4'd8) m_coef[a] = sext(d);
        else if (a == 4'd9) m_shift = int'(d[3:0]);
        else if (a == 4'd10) begin
            if (d[0]) begin
                m_coef  = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
                m_shift = 4;
            end else model_reset();
        end
    endfunction

    // Returns {clip, pix}.
    function automatic logic [8:0] model(input logic [71:0] pix, input logic [3:0] b);
        logic [8:0] m;
        int s;
        case (b)
            4'd0: m = 9'h000;
            4'd1: m = 9'h011;
            4'd2: m = 9'h014;
            4'd3: m = 9'h051;
            4'd4: m = 9'h114;
            4'd5: m = 9'h050;
            4'd6: m = 9'h110;
            default: m = 9'h1FF;
        endcase
        s = 0;
        for (int k = 0; k < 9; k++)
            if (m[k]) s += int'(pix[k*8 +: 8]) * m_coef[k];
        if (m_shift > 0) s = (s + (1 << (m_shift - 1))) >>> m_shift;
        if (s < 0) return {1'b1, 8'd0};
        if (s > 255) return {1'b1, 8'd255};
        return {1'b0, 8'(s)};
    endfunction

    // Window from centre, corner (taps 0,2,6,8) and edge (taps 1,3,5,7) values.
    function automatic logic [71:0] win(input int c, input int corner, input int edge_v);
        logic [71:0] w;
        for (int k = 0; k < 9; k++) begin
            if (k == 4) w[k*8 +: 8] = 8'(c);
            else if (k == 0 || k == 2 || k == 6 || k == 8) w[k*8 +: 8] = 8'(corner);
            else w[k*8 +: 8] = 8'(edge_v);
        end
        return w;
    endfunction

    function automatic logic [71:0] rand_win();
        logic [71:0] w;
        for (int k = 0; k < 9; k++) w[k*8 +: 8] = 8'($urandom_range(255, 0));
        return w;
    endfunction

    // Scoreboard: push on accepted windows, pop on delivered results.
    task automatic monitor();
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                model_reset();
            end else begin
                if (out_valid && out_ready) begin
                    n_checks++;
                    n_out++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL unexpected_output got pix=%0d clip=%0b required no output",
                                 out_pix, out_clip);
                    end else begin
                        e = exp_q.pop_front();
                        if ({out_clip, out_pix} !== e) begin
                            n_errors++;
                            $display("FAIL result#%0d got pix=%0d clip=%0b required pix=%0d clip=%0b",
                                     n_out, out_pix, out_clip, e[7:0], e[8]);
                        end
                    end
                end
                if (in_valid && in_ready) exp_q.push_back(model(in_pix, in_border));
                if (cfg_we) model_cfg(cfg_addr, cfg_wdata);
            end
        end
    endtask

    task automatic send(input logic [71:0] pix, input logic [3:0] b);
        logic acc;
        int waited;
        in_pix = pix; in_border = b; in_valid = 1'b1;
        acc = 1'b0; waited = 0;
        while (!acc && waited < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            waited++;
        end
        in_valid = 1'b0;
        n_checks++;
        if (!acc) begin
            n_errors++;
            $display("FAIL send_timeout got in_ready=0 for %0d cycles required accept", waited);
        end
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int expect_n, input int start_out);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_drain got pending=%0d required 0", name, exp_q.size());
        end
        n_checks++;
        if (n_out - start_out != expect_n) begin
            n_errors++;
            $display("FAIL %s_count got %0d outputs required %0d", name, n_out - start_out, expect_n);
        end
    endtask

    task automatic test_reset();
        int lat, s0;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = 4'd0; cfg_wdata = 8'd0;
        in_valid = 1'b0; in_pix = '0; in_border = 4'd8; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid got %b required 0", out_valid); end
        n_checks++;
        if (out_pix !== 8'd0) begin n_errors++; $display("FAIL reset_out_pix got %0d required 0", out_pix); end
        n_checks++;
        if (out_clip !== 1'b0) begin n_errors++; $display("FAIL reset_out_clip got %b required 0", out_clip); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready got %b required 1", in_ready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        s0 = n_out;
        in_pix = win(100, 100, 100); in_border = 4'd8; in_valid = 1'b1;
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (out_valid) lat = c;
        end
        n_checks++;
        if (lat != 3) begin n_errors++; $display("FAIL latency got %0d required 3", lat); end
        wait_drain("reset_default", 1, s0);
    endtask

    task automatic test_saturation();
        int s0 = n_out;
        send(win(100, 0, 0), 4'd8);
        send(win(0, 10, 0), 4'd8);
        send(win(255, 0, 0), 4'd8);
        send(win(30, 10, 200), 4'd8);
        wait_drain("saturation", 4, s0);
    endtask

    task automatic test_gaussian();
        int s0 = n_out;
        cfg_write(4'd10, 8'd1);
        send(win(100, 100, 100), 4'd8);
        send(win(3, 0, 0), 4'd8);
        for (int i = 0; i < 3; i++) send(rand_win(), 4'd8);
        cfg_write(4'd10, 8'd0);
        wait_drain("gaussian", 5, s0);
    endtask

    task automatic test_border();
        int s0 = n_out;
        logic [71:0] w;
        w = win(20, 255, 255);
        w[7:0] = 8'd50;
        send(w, 4'd1);
        send(rand_win(), 4'd0);
        for (int b = 2; b < 16; b++) send(rand_win(), 4'(b));
        cfg_write(4'd10, 8'd1);
        for (int b = 0; b < 8; b++) send(rand_win(), 4'(b));
        cfg_write(4'd10, 8'd0);
        wait_drain("border", 24, s0);
    endtask

    task automatic test_coef_shift();
        int s0 = n_out;
        logic [71:0] w;
        cfg_write(4'd4, 8'h25);
        cfg_write(4'd0, 8'h1F);
        cfg_write(4'd1, 8'h10);
        cfg_write(4'd9, 8'hF3);
        cfg_write(4'd11, 8'h00);
        cfg_write(4'd15, 8'h07);
        w = win(50, 0, 0);
        w[7:0] = 8'd10;
        w[15:8] = 8'd3;
        send(w, 4'd8);
        for (int i = 0; i < 4; i++) send(rand_win(), 4'(i * 3));
        cfg_write(4'd3, 8'h0F);
        cfg_write(4'd9, 8'h00);
        for (int i = 0; i < 3; i++) send(rand_win(), 4'd9);
        cfg_write(4'd10, 8'd0);
        wait_drain("coef_shift", 8, s0);
    endtask

    task automatic test_back_to_back();
        int s0 = n_out;
        logic [7:0] held;
        logic held_ok;
        cfg_write(4'd10, 8'd1);
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) send(win(16 * i + 5, 8 * i, 40 + 20 * i), 4'd8);
            end
            begin
                repeat (3) @(posedge clk);
                #2;
                out_ready = 1'b0;
                held_ok = 1'b0;
                held = 8'd0;
                for (int c = 0; c < 5; c++) begin
                    if (c == 1) begin
                        cfg_we = 1'b1; cfg_addr = 4'd9; cfg_wdata = 8'd5;
                    end else cfg_we = 1'b0;
                    @(posedge clk); #2;
                    n_checks++;
                    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                        n_errors++;
                        $display("FAIL stall_full got out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
                    end
                    if (held_ok) begin
                        n_checks++;
                        if (out_pix !== held) begin
                            n_errors++;
                            $display("FAIL stall_hold got pix=%0d required %0d", out_pix, held);
                        end
                    end
                    held = out_pix;
                    held_ok = 1'b1;
                end
                cfg_we = 1'b0;
                out_ready = 1'b1;
            end
        join
        wait_drain("back_to_back", 6, s0);
        cfg_write(4'd10, 8'd0);
    endtask

    task automatic test_reset_mid();
        int s0;
        cfg_write(4'd10, 8'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(rand_win(), 4'd8);
        n_checks++;
        if (out_valid !== 1'b1) begin n_errors++; $display("FAIL mid_pre_valid got %b required 1", out_valid); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL mid_reset_valid got %b required 0", out_valid); end
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        s0 = n_out;
        send(win(100, 100, 100), 4'd8);
        send(win(100, 0, 0), 4'd8);
        wait_drain("reset_mid", 2, s0);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_saturation();
        test_gaussian();
        test_border();
        test_coef_shift();
        test_back_to_back();
        test_reset_mid();
        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
